// File: rtl/packet_streamer_ring.sv
// Ring-buffered ADC sample packetiser: fills 2^NBUF_LOG2 payload buffers and streams each full one
// as a raw Ethernet frame on a GMII byte interface. Define VLAN_TAG_EN to insert an 802.1Q tag.
module packet_streamer_ring #(
  parameter int          WORDS_LOG2 = 9,
  parameter int          NBUF_LOG2  = 2,
  parameter logic [47:0] DEST_MAC   = 48'hffffffffffff,
  parameter logic [47:0] SRC_MAC    = 48'h000102030409,
  parameter logic [15:0] ETHERTYPE  = 16'h9800,
  parameter int          IPG_BYTES  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] source_data,
  input  logic        source_en,
  input  logic [15:0] vlan_tci,
  output logic [7:0]  tx_data,
  output logic [1:0]  tx_ctl,
  output logic [15:0] overflow_count,
  output logic [31:0] seq
);

  localparam int NWORDS = 1 << WORDS_LOG2;
  localparam int NBUF   = 1 << NBUF_LOG2;
  localparam logic [15:0] PAY_BYTES = 16'(2 * NWORDS);
  localparam logic [15:0] IPG_LEN   = 16'(IPG_BYTES);
  localparam logic [WORDS_LOG2-1:0] LAST_WORD = '1;

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, DEST, SRC,
`ifdef VLAN_TAG_EN
    VLAN,
`endif
    TYPE, SEQ, TICKS, PAYLOAD, FCS, IPG
  } state_t;

  logic [15:0]           ram [NBUF*NWORDS];
  logic [63:0]           ticks_mem [NBUF];
  logic [31:0]           seqn_mem [NBUF];
  logic [NBUF-1:0]       full;
  logic [NBUF_LOG2-1:0]  wbuf, rbuf;
  logic [WORDS_LOG2-1:0] widx, ra;
  logic                  skip;
  logic [63:0]           c;

  state_t      state, state_next, seg_next;
  logic [15:0] cnt, cnt_next, seg_len;
  logic [7:0]  byte_next;
  logic [1:0]  ctl_next;
  logic        crc_en, crc_rst;
  logic [15:0] rd_word;
  logic [31:0] crc, fcs_word;
  logic [23:0] fcs_lo;

  logic release_buf, wbuf_free, go_skip, wr;

`ifdef VLAN_TAG_EN
  logic [15:0] vlan_q;
`else
  logic unused_vlan;
  assign unused_vlan = ^vlan_tci;
`endif

  function automatic logic [7:0] pick(input logic [63:0] v, input int n, input logic [15:0] k);
    logic [63:0] s;
    s = v >> (8 * (n - 1 - int'(k)));
    return s[7:0];
  endfunction

  // reflected IEEE 802.3 polynomial, data LSB first as it goes on the wire
  function automatic logic [31:0] crc_byte(input logic [31:0] r, input logic [7:0] d);
    logic [31:0] x;
    x = r;
    for (int i = 0; i < 8; i++)
      x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hedb88320) : (x >> 1);
    return x;
  endfunction

  // Writer: a buffer released by the reader this cycle counts as free
  assign release_buf = (state == FCS) && (cnt == 16'd3);
  assign wbuf_free   = !full[wbuf] || (release_buf && (rbuf == wbuf));
  assign go_skip     = source_en && !skip && (widx == '0) && !wbuf_free;
  assign wr          = source_en && !skip && !go_skip;

  always_ff @(posedge clk) begin
    if (reset) begin
      c              <= '0;
      full           <= '0;
      wbuf           <= '0;
      rbuf           <= '0;
      widx           <= '0;
      skip           <= 1'b0;
      overflow_count <= '0;
      seq            <= '0;
    end else begin
      c <= c + 64'd1;
      if (release_buf) begin
        full[rbuf] <= 1'b0;
        rbuf       <= rbuf + 1'b1;
      end
      if (source_en) begin
        widx <= widx + 1'b1;
        if (go_skip) begin
          skip <= 1'b1;
          seq  <= seq + 32'd1;
          if (overflow_count != 16'hffff) overflow_count <= overflow_count + 16'd1;
        end else if (skip) begin
          if (widx == LAST_WORD) skip <= 1'b0;
        end else if (widx == LAST_WORD) begin
          full[wbuf] <= 1'b1;
          wbuf       <= wbuf + 1'b1;
          seq        <= seq + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr) ram[{wbuf, widx}] <= source_data;
    if (wr && (widx == '0)) begin
      ticks_mem[wbuf] <= c;
      seqn_mem[wbuf]  <= seq;
    end
    rd_word <= ram[{rbuf, ra}];
    if (crc_rst) crc <= '1;
    else if (crc_en) crc <= crc_byte(crc, byte_next);
    if ((state == FCS) && (cnt == 16'd0)) fcs_lo <= fcs_word[23:0];
`ifdef VLAN_TAG_EN
    if ((state == IDLE) && full[rbuf]) vlan_q <= vlan_tci;
`endif
  end

  assign fcs_word = ~{crc[7:0], crc[15:8], crc[23:16], crc[31:24]};

  // Reader: state/cnt select the byte registered onto tx_data at the next edge
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 16'd1;
    byte_next  = 8'h00;
    ctl_next   = 2'b00;
    crc_en     = 1'b0;
    crc_rst    = 1'b0;
    seg_len    = 16'd1;
    seg_next   = IDLE;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (full[rbuf]) state_next = PREAMBLE;
      end
      PREAMBLE: begin
        ctl_next  = 2'b11;
        crc_rst   = 1'b1;
        byte_next = (cnt == 16'd7) ? 8'hd5 : 8'h55;
        seg_len   = 16'd8;
        seg_next  = DEST;
      end
      DEST: begin
        ctl_next  = 2'b11;
        crc_en    = 1'b1;
        byte_next = pick({16'd0, DEST_MAC}, 6, cnt);
        seg_len   = 16'd6;
        seg_next  = SRC;
      end
      SRC: begin
        ctl_next  = 2'b11;
        crc_en    = 1'b1;
        byte_next = pick({16'd0, SRC_MAC}, 6, cnt);
        seg_len   = 16'd6;
`ifdef VLAN_TAG_EN
        seg_next  = VLAN;
`else
        seg_next  = TYPE;
`endif
      end
`ifdef VLAN_TAG_EN
      VLAN: begin
        ctl_next  = 2'b11;
        crc_en    = 1'b1;
        byte_next = pick({32'd0, 16'h8100, vlan_q}, 4, cnt);
        seg_len   = 16'd4;
        seg_next  = TYPE;
      end
`endif
      TYPE: begin
        ctl_next  = 2'b11;
        crc_en    = 1'b1;
        byte_next = pick({48'd0, ETHERTYPE}, 2, cnt);
        seg_len   = 16'd2;
        seg_next  = SEQ;
      end
      SEQ: begin
        ctl_next  = 2'b11;
        crc_en    = 1'b1;
        byte_next = pick({32'd0, seqn_mem[rbuf]}, 4, cnt);
        seg_len   = 16'd4;
        seg_next  = TICKS;
      end
      TICKS: begin
        ctl_next  = 2'b11;
        crc_en    = 1'b1;
        byte_next = pick(ticks_mem[rbuf], 8, cnt);
        seg_len   = 16'd8;
        seg_next  = PAYLOAD;
      end
      PAYLOAD: begin
        ctl_next  = 2'b11;
        crc_en    = 1'b1;
        byte_next = cnt[0] ? rd_word[7:0] : rd_word[15:8];
        seg_len   = PAY_BYTES;
        seg_next  = FCS;
      end
      FCS: begin
        ctl_next  = 2'b11;
        byte_next = (cnt == 16'd0) ? fcs_word[31:24] : pick({40'd0, fcs_lo}, 3, cnt - 16'd1);
        seg_len   = 16'd4;
        seg_next  = IPG;
      end
      IPG: begin
        seg_len  = IPG_LEN;
        seg_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if ((state != IDLE) && (cnt == seg_len - 16'd1)) begin
      state_next = seg_next;
      cnt_next   = '0;
    end
  end

  // Output stage; the read address runs one word ahead of the byte being sent
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ra      <= '0;
      tx_data <= '0;
      tx_ctl  <= 2'b00;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      tx_data <= byte_next;
      tx_ctl  <= ctl_next;
      if (state != PAYLOAD) ra <= '0;
      else if (!cnt[0]) ra <= ra + 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_streamer_ring.sv
// Bench for packet_streamer_ring (WORDS_LOG2=4, NBUF_LOG2=1): frame receiver with software CRC-32
// plus a seq/ticks scoreboard; also exercises overflow, mid-frame reset and the release race.
module tb_packet_streamer_ring;
  localparam int NW = 16;
`ifdef VLAN_TAG_EN
  localparam int VB = 4;
`else
  localparam int VB = 0;
`endif
  localparam int FRAME_LEN = 8 + 26 + VB + 2 * NW + 4;
  localparam int TYPE_OFF  = 20 + VB;
  localparam int SEQ_OFF   = TYPE_OFF + 2;
  localparam int TICK_OFF  = SEQ_OFF + 4;
  localparam int PAY_OFF   = TICK_OFF + 8;
  localparam int FCS_OFF   = PAY_OFF + 2 * NW;
  localparam int REL       = NW + FRAME_LEN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] source_data = '0;
  logic        source_en = 1'b0;
  logic [15:0] vlan_tci = 16'h2005;
  logic [7:0]  tx_data;
  logic [1:0]  tx_ctl;
  logic [15:0] overflow_count;
  logic [31:0] seq;

  packet_streamer_ring #(.WORDS_LOG2(4), .NBUF_LOG2(1)) dut (
    .clk(clk), .reset(reset), .source_data(source_data), .source_en(source_en),
    .vlan_tci(vlan_tci), .tx_data(tx_data), .tx_ctl(tx_ctl),
    .overflow_count(overflow_count), .seq(seq)
  );

  always #4 clk = ~clk;

  logic [63:0] tbc;
  always @(posedge clk) if (reset) tbc <= '0; else tbc <= tbc + 64'd1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] s; logic [63:0] t; } sb_t;
  sb_t         sb_q[$];
  bit          sb_en = 1'b1;
  logic [31:0] rx_seq[$];
  logic [63:0] rx_ticks[$];
  int          frames_rx = 0;

  logic [7:0] src_b [6] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h09};
  logic [7:0] rx [128];
  int rx_n = 0;
  int idle_n = 0;
  bit in_frame = 0, drop = 0, have_prev = 0;

  task automatic check_frame();
    int bad;
    logic [31:0] s, r, fcs;
    logic [63:0] t;
    sb_t e;
    check("frame_len", 64'(rx_n), 64'(FRAME_LEN));
    if (rx_n != FRAME_LEN) return;
    bad = 0;
    for (int i = 0; i < 7; i++) if (rx[i] != 8'h55) bad++;
    if (rx[7] != 8'hd5) bad++;
    for (int i = 0; i < 6; i++) begin
      if (rx[8+i] != 8'hff) bad++;
      if (rx[14+i] != src_b[i]) bad++;
    end
`ifdef VLAN_TAG_EN
    if (rx[20] != 8'h81 || rx[21] != 8'h00 || rx[22] != 8'h20 || rx[23] != 8'h05) bad++;
`endif
    if (rx[TYPE_OFF] != 8'h98 || rx[TYPE_OFF+1] != 8'h00) bad++;
    check("header_bytes_bad", 64'(bad), 64'd0);
    s = {rx[SEQ_OFF], rx[SEQ_OFF+1], rx[SEQ_OFF+2], rx[SEQ_OFF+3]};
    t = '0;
    for (int i = 0; i < 8; i++) t = {t[55:0], rx[TICK_OFF+i]};
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (rx[PAY_OFF+2*i] != s[7:0] || rx[PAY_OFF+2*i+1] != 8'(i)) bad++;
    check("payload_bad", 64'(bad), 64'd0);
    r = 32'hffffffff;
    for (int i = 8; i < FCS_OFF; i++) begin
      r = r ^ {24'd0, rx[i]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
    end
    fcs = ~r;
    check("fcs", {32'd0, rx[FCS_OFF+3], rx[FCS_OFF+2], rx[FCS_OFF+1], rx[FCS_OFF]}, {32'd0, fcs});
    rx_seq.push_back(s);
    rx_ticks.push_back(t);
    frames_rx++;
    if (sb_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: seq %0h with empty scoreboard", s);
      end else begin
        e = sb_q.pop_front();
        check("seq_field", {32'd0, s}, {32'd0, e.s});
        check("ticks_field", t, e.t);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      drop = 1;
      have_prev = 0;
    end
    if (tx_ctl == 2'b11) begin
      if (!in_frame) begin
        in_frame = 1;
        rx_n = 0;
        if (have_prev && !drop) check("ipg_at_least_12", 64'(idle_n >= 12), 64'd1);
      end
      if (rx_n < 128) rx[rx_n] = tx_data;
      rx_n++;
    end else begin
      if (in_frame) begin
        in_frame = 0;
        if (!drop) begin
          check_frame();
          have_prev = 1;
        end
        idle_n = 1;
      end else idle_n++;
      if (!reset) drop = 0;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    source_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    sb_q.delete();
    rx_seq.delete();
    rx_ticks.delete();
  endtask

  // Buffer b carries words {b, index} so a receiver can check payload against the seq field
  task automatic send_buf(input int b, input int gap, input bit push);
    logic [63:0] t0;
    t0 = '0;
    for (int i = 0; i < NW; i++) begin
      if (i == 0) t0 = tbc;
      source_en = 1'b1;
      source_data = {8'(b), 8'(i)};
      @(posedge clk); #1;
      source_en = 1'b0;
      for (int g = 1; g < gap; g++) begin @(posedge clk); #1; end
    end
    if (push) sb_q.push_back('{32'(b), t0});
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_rx < n && k < budget) begin @(posedge clk); #1; k++; end
    check("frames_arrived", 64'(frames_rx), 64'(n));
  endtask

  typedef struct { int nbuf; int gap; bit use_sb; logic [31:0] exp_seq; logic [15:0] exp_ovf; } vec_t;

  initial begin
    vec_t vecs[4];
    int base, nexp, k, missing;
    vecs[0] = '{1, 1, 1'b1, 32'd1, 16'd0};
    vecs[1] = '{2, 1, 1'b1, 32'd2, 16'd0};
    vecs[2] = '{3, 6, 1'b1, 32'd3, 16'd0};
    vecs[3] = '{6, 1, 1'b0, 32'd6, 16'd4};

    do_reset();
    check("rst_tx_ctl", {62'd0, tx_ctl}, 64'd0);
    check("rst_tx_data", {56'd0, tx_data}, 64'd0);
    check("rst_overflow", {48'd0, overflow_count}, 64'd0);
    check("rst_seq", {32'd0, seq}, 64'd0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      sb_en = vecs[v].use_sb;
      base = frames_rx;
      for (int b = 0; b < vecs[v].nbuf; b++) send_buf(b, vecs[v].gap, vecs[v].use_sb);
      nexp = vecs[v].nbuf - int'(vecs[v].exp_ovf);
      wait_frames(base + nexp, 3000);
      repeat (40) @(posedge clk);
      #1;
      check("frame_count", 64'(frames_rx - base), 64'(nexp));
      check("seq_port", {32'd0, seq}, {32'd0, vecs[v].exp_seq});
      check("overflow_count", {48'd0, overflow_count}, {48'd0, vecs[v].exp_ovf});
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      if (vecs[v].use_sb) begin
        for (int i = 1; i < rx_ticks.size(); i++)
          check("ticks_interval", rx_ticks[i] - rx_ticks[i-1], 64'(NW * vecs[v].gap));
      end else if (rx_seq.size() > 0) begin
        missing = int'(rx_seq[0]);
        for (int i = 1; i < rx_seq.size(); i++) missing += int'(rx_seq[i] - rx_seq[i-1]) - 1;
        missing += vecs[v].nbuf - 1 - int'(rx_seq[rx_seq.size()-1]);
        check("seq_gaps_vs_overflow", 64'(missing), {48'd0, overflow_count});
      end
    end

    // Reset while frame seq=1 is in its payload
    do_reset();
    sb_en = 1'b1;
    base = frames_rx;
    send_buf(0, 1, 1'b1);
    send_buf(1, 1, 1'b1);
    wait_frames(base + 1, 500);
    k = 0;
    while (!(in_frame && rx_n >= PAY_OFF + 6) && k < 500) begin @(posedge clk); #1; k++; end
    check("reached_payload_seq1", 64'(in_frame && rx_n >= PAY_OFF + 6), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_tx_ctl", {62'd0, tx_ctl}, 64'd0);
    check("midrst_overflow", {48'd0, overflow_count}, 64'd0);
    check("midrst_seq", {32'd0, seq}, 64'd0);
    sb_q.delete();
    base = frames_rx;
    send_buf(0, 1, 1'b1);
    wait_frames(base + 1, 500);
    check("post_reset_frame_seq", {32'd0, rx_seq[rx_seq.size()-1]}, 64'd0);
    check("post_reset_sb_drained", 64'(sb_q.size()), 64'd0);

    // Writer wraps onto buffer 0 on the exact edge its last FCS byte is driven
    do_reset();
    sb_en = 1'b1;
    base = frames_rx;
    send_buf(0, 1, 1'b1);
    send_buf(1, 1, 1'b1);
    k = 0;
    while (tbc < 64'(REL) && k < 500) begin @(posedge clk); #1; k++; end
    check("race_cycle_reached", tbc, 64'(REL));
    send_buf(2, 1, 1'b1);
    wait_frames(base + 3, 1000);
    repeat (20) @(posedge clk);
    #1;
    check("race_overflow", {48'd0, overflow_count}, 64'd0);
    check("race_seq", {32'd0, seq}, 64'd3);
    check("race_sb_drained", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
